seven_segment_scanner: RTL and testbench
========================================

// Module: seven_segment_scanner
// PURPOSE
//   Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display.
//   Holds a hex value, scans one digit per refresh slot and decodes each nibble to segments.
//   Value updates are double-buffered and applied only at frame boundaries, so the display never tears.
//   Sits between the temperature/control datapath and the board display pins.
// PARAMETERS
//   NUM_DIGITS     4      digits driven (1..8); digit 0 is rightmost, value[3:0]
//   CLK_DIV        50000  clk cycles per digit slot (>=1); counter width $clog2(CLK_DIV+1)
//   SEG_ACTIVE_LOW 1      1: seg bit low = lit; 0: entire seg byte inverted
//   AN_ACTIVE_LOW  1      1: an bit low = digit enabled; 0: an inverted
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             asynchronous reset, active low
//   wr_valid    in   1             single-cycle strobe: capture wr_value/wr_dp/wr_blank
//   wr_value    in   4*NUM_DIGITS  hex nibbles, digit i = wr_value[4i+3:4i]
//   wr_dp       in   NUM_DIGITS    decimal point request per digit (1 = lit)
//   wr_blank    in   NUM_DIGITS    force digit i dark (1 = blank)
//   seg         out  8             {a,b,c,d,e,f,g,dp}: seg[7]=a .. seg[1]=g, seg[0]=dp
//   an          out  NUM_DIGITS    digit enables, one-hot active during scan
//   frame_start out  1             1-cycle pulse when digit 0 begins a new frame
// BEHAVIOUR
//   Clock is clk only; reset is asynchronous, active-low (rst_n); assertion mid-scan clears all state immediately.
//   Reset values: seg=8'hFF (all dark, SEG_ACTIVE_LOW=1), an all inactive, frame_start=0,
//     prescaler=0, digit index=0, pending and display registers (value/dp/blank) all 0.
//   Prescaler counts 0..CLK_DIV-1; tick asserted when count==CLK_DIV-1, count then wraps to 0.
//   On tick: digit index advances i -> i+1, NUM_DIGITS-1 -> 0 (wrap = frame boundary).
//   Write path: wr_valid loads the pending registers (last write wins, no backpressure).
//   At the frame-boundary tick, display registers <= pending registers. A wr_valid in that same
//     cycle lands in pending only and is shown from the following frame.
//   Outputs are registered: seg/an/frame_start reflect the new digit index 1 cycle after tick.
//   frame_start = 1 for exactly the cycle in which an first selects digit 0.
//   Decode (active-low byte, hex): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09
//     A:11 b:C1 C:63 d:85 E:61 F:71. dp lit clears seg[0].
//   Blanked digit: seg all dark (incl. dp) and its an bit inactive for its whole slot.
//   NUM_DIGITS=1: index stays 0, every tick is a frame boundary, frame_start pulses every slot.
//   CLK_DIV=1: tick every cycle; scan still strictly one-hot, no skipped digits.
//   Polarity parameters apply last, after decode/blank/dp logic.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits above the most-significant nonzero nibble of the display
//     register are blanked (same effect as wr_blank); digit 0 is never suppressed, so value 0
//     shows "0"; a suppressed digit's dp is also dark.
//   Not defined: every non-wr_blank digit is shown, leading zeros included; no extra logic built.
// TESTING (NUM_DIGITS=4, CLK_DIV=4, active-low polarities unless stated)
//   Reset: rst_n=0 -> seg=FF, an=4'b1111, frame_start=0; release -> an=1110 within 5 clk, scan
//     1110,1101,1011,0111, 4 clk each, frame_start every 16 clk.
//   Write 16'h12AF, wr_dp=0001 -> from next frame digits 0..3 show seg 70,11,25,9F; never mixed
//     with old value within one frame.
//   wr_valid on the frame-boundary tick cycle with 16'h0005 -> that frame shows old value,
//     next frame shows 05.
//   wr_blank=0100 -> digit 2 slot: seg=FF, an=1111; others unaffected.
//   LEADING_ZERO_BLANK_EN, value 16'h0030 -> digits 3,2 dark; digits 1,0 show 0D,03; value
//     16'h0000 -> only digit 0 lit with 03. Without macro: all four digits show.
//   Assert rst_n mid-slot of digit 2 -> same cycle seg=FF, an=1111; after release scan restarts
//     at digit 0 with display registers 0.

Source files
------------

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - write port and display pins of the 7-segment scanner
// master drives display writes and watches the pins; slave is the scanner itself.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    wr_valid;
  logic [4*NUM_DIGITS-1:0] wr_value;
  logic [NUM_DIGITS-1:0]   wr_dp;
  logic [NUM_DIGITS-1:0]   wr_blank;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output wr_valid, wr_value, wr_dp, wr_blank,
    input  seg, an, frame_start
  );

  modport slave (
    input  wr_valid, wr_value, wr_dp, wr_blank,
    output seg, an, frame_start
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed N-digit hex 7-segment driver
// Optional LEADING_ZERO_BLANK_EN darkens digits above the most-significant nonzero nibble.
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  seven_segment_scanner_if.slave bus
);
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_DARK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_DARK  = AN_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_value, r_disp_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank, r_disp_blank;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic                  w_tick;
  logic                  w_last;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_blank;
  logic                  w_upper_zero;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [7:0]            w_seg_low;
  logic [NUM_DIGITS-1:0] w_an_low;

  function automatic logic [7:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 8'h03;
      4'h1: f_decode = 8'h9F;
      4'h2: f_decode = 8'h25;
      4'h3: f_decode = 8'h0D;
      4'h4: f_decode = 8'h99;
      4'h5: f_decode = 8'h49;
      4'h6: f_decode = 8'h41;
      4'h7: f_decode = 8'h1F;
      4'h8: f_decode = 8'h01;
      4'h9: f_decode = 8'h09;
      4'hA: f_decode = 8'h11;
      4'hB: f_decode = 8'hC1;
      4'hC: f_decode = 8'h63;
      4'hD: f_decode = 8'h85;
      4'hE: f_decode = 8'h61;
      default: f_decode = 8'h71;
    endcase
  endfunction

  assign w_tick = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Running AND from the top digit down; digit 0 is never suppressed.
  always_comb begin
    w_lz         = '0;
    w_upper_zero = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_upper_zero = w_upper_zero && (r_disp_value[4*i +: 4] == 4'h0);
      w_lz[i]      = w_upper_zero;
    end
`endif
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp     = 1'b0;
    w_blank  = 1'b0;
    w_an_low = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib   = r_disp_value[4*i +: 4];
        w_dp    = r_disp_dp[i];
        w_blank = r_disp_blank[i] | w_lz[i];
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_low[i] = !((r_idx == IDX_W'(i)) && !w_blank);
    end
    w_seg_low = w_blank ? 8'hFF : (f_decode(w_nib) & ~{7'b0, w_dp});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pend_value  <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_disp_value  <= '0;
      r_disp_dp     <= '0;
      r_disp_blank  <= '0;
      r_seg         <= SEG_DARK;
      r_an          <= AN_DARK;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (bus.wr_valid) begin
        r_pend_value <= bus.wr_value;
        r_pend_dp    <= bus.wr_dp;
        r_pend_blank <= bus.wr_blank;
      end
      // Frame boundary: a write in this same cycle is not yet visible here.
      if (w_tick && w_last) begin
        r_disp_value <= r_pend_value;
        r_disp_dp    <= r_pend_dp;
        r_disp_blank <= r_pend_blank;
      end
      r_seg         <= SEG_ACTIVE_LOW ? w_seg_low : ~w_seg_low;
      r_an          <= AN_ACTIVE_LOW ? w_an_low : ~w_an_low;
      r_frame_start <= (r_idx == '0) && (r_cnt == '0);
    end
  end

  assign bus.seg         = r_seg;
  assign bus.an          = r_an;
  assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - randomized self-checking bench for seven_segment_scanner
// Reference model tracks expected display contents per frame from elapsed clock count.
module tb_seven_segment_scanner;
  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int FRAME = ND * CD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  logic [7:0] dec [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [7:0] dir_12af [4] = '{8'h70, 8'h11, 8'h25, 8'h9F};

  logic [15:0] pend_v, snap_v, disp_v, wq_v;
  logic [3:0]  pend_dp, snap_dp, disp_dp, wq_dp;
  logic [3:0]  pend_b, snap_b, disp_b, wq_b;
  logic        wq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic reset_model();
    pend_v = '0; snap_v = '0; disp_v = '0;
    pend_dp = '0; snap_dp = '0; disp_dp = '0;
    pend_b = '0; snap_b = '0; disp_b = '0;
    wq = 1'b0; wq_v = '0; wq_dp = '0; wq_b = '0;
    k = 0;
  endtask

  function automatic bit lz_dark(input logic [15:0] v, input int d);
    if (!LZB || d == 0) return 1'b0;
    return (v >> (4 * d)) == 16'h0;
  endfunction

  task automatic drive_write(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_value = v;
    bus.wr_dp    = dp;
    bus.wr_blank = b;
    wq = 1'b1; wq_v = v; wq_dp = dp; wq_b = b;
  endtask

  // One clock: advance the model to the state after edge k, then compare all pins.
  task automatic cycle();
    int d;
    bit blank;
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    @(negedge clk);
    k++;
    bus.wr_valid = 1'b0;
    if (wq) begin
      pend_v = wq_v; pend_dp = wq_dp; pend_b = wq_b; wq = 1'b0;
    end
    if (k % FRAME == FRAME - 1) begin
      snap_v = pend_v; snap_dp = pend_dp; snap_b = pend_b;
    end
    if (k % FRAME == 1 && k > 1) begin
      disp_v = snap_v; disp_dp = snap_dp; disp_b = snap_b;
    end
    d = ((k - 1) / CD) % ND;
    blank = disp_b[d] || lz_dark(disp_v, d);
    if (blank) begin
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
    end else begin
      exp_seg = dec[(disp_v >> (4 * d)) & 16'hF] & ~{7'b0, disp_dp[d]};
      exp_an  = 4'b1 << d;
      exp_an  = ~exp_an;
    end
    check("an", bus.an, exp_an);
    check("seg", bus.seg, exp_seg);
    check("frame_start", bus.frame_start, ((k - 1) % FRAME == 0));
  endtask

  task automatic random_write();
    logic [15:0] v;
    v = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
    drive_write(v, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
  endtask

  initial begin
    bit found;
    bus.wr_valid = 1'b0;
    bus.wr_value = '0;
    bus.wr_dp    = '0;
    bus.wr_blank = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_an", bus.an, 4'hF);
    check("rst_fs", bus.frame_start, 1'b0);
    rst_n = 1'b1;

    for (int c = 0; c < 150; c++) begin
      cycle();
      if (k >= 17 && k <= 29 && (k - 1) % CD == 0) check("wr_12af", bus.seg, dir_12af[(k - 17) / CD]);
      if (k == 33) check("tick_old", bus.seg, 8'h70);
      if (k == 49) check("tick_new", bus.seg, 8'h49);
      if (k == 61) check("lead_d3", bus.seg, LZB ? 8'hFF : 8'h03);
      if (k == 69) check("blank_other", bus.seg, 8'h0D);
      if (k == 73) begin
        check("blank_seg", bus.seg, 8'hFF);
        check("blank_an", bus.an, 4'hF);
      end
      if (k == 97)  check("lz30_d0", bus.seg, 8'h03);
      if (k == 101) check("lz30_d1", bus.seg, 8'h0D);
      if (k == 105) check("lz30_d2", bus.seg, LZB ? 8'hFF : 8'h03);
      if (k == 109) check("lz30_d3", bus.seg, LZB ? 8'hFF : 8'h03);
      if (k == 129) check("lz0_d0", bus.seg, 8'h03);
      if (k == 133) check("lz0_d1", bus.seg, LZB ? 8'hFF : 8'h03);
      case (k)
        3:   drive_write(16'h12AF, 4'b0001, 4'b0000);
        31:  drive_write(16'h0005, 4'b0000, 4'b0000);
        50:  drive_write(16'h1234, 4'b0000, 4'b0100);
        81:  drive_write(16'h0030, 4'b0000, 4'b0000);
        113: drive_write(16'h0000, 4'b0000, 4'b0000);
        default: ;
      endcase
    end

    for (int c = 0; c < 450; c++) begin
      cycle();
      if ($urandom_range(0, 7) == 0 || (k % FRAME == FRAME - 1 && $urandom_range(0, 1) == 1))
        random_write();
    end

    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      cycle();
      if (((k - 1) / CD) % ND == 2 && (k - 1) % CD == 1) found = 1'b1;
    end
    check("find_digit2", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_seg", bus.seg, 8'hFF);
    check("midrst_an", bus.an, 4'hF);
    check("midrst_fs", bus.frame_start, 1'b0);
    repeat (2) @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    cycle();
    check("restart_an", bus.an, 4'hE);
    check("restart_seg", bus.seg, 8'h03);

    for (int c = 0; c < 300; c++) begin
      cycle();
      if ($urandom_range(0, 5) == 0 || (k % FRAME == FRAME - 1 && $urandom_range(0, 1) == 1))
        random_write();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
